// File: rtl/axi_read_router.sv
// AXI read-channel router: round-robin AR arbitration between two masters,
// registered Mux_2 steering pointers, and internal DECERR bursts.
module axi_read_router #(
    parameter int ADDR_W           = 32,
    parameter int LEN_W            = 4,
    parameter int AXI_POINTER_BITS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arvalid_m0,
    input  logic                        arvalid_m1,
    input  logic [ADDR_W-1:0]           araddr_m0,
    input  logic [ADDR_W-1:0]           araddr_m1,
    input  logic [LEN_W-1:0]            arlen_m0,
    input  logic [LEN_W-1:0]            arlen_m1,
    input  logic                        arready_s,
    input  logic                        rvalid_s,
    input  logic                        rlast_s,
    input  logic                        rready_m,
    output logic [AXI_POINTER_BITS-1:0] m_ptr,
    output logic [AXI_POINTER_BITS-1:0] s_ptr,
    output logic                        ar_en,
    output logic                        r_en,
    output logic                        err_arready,
    output logic                        err_rvalid,
    output logic                        err_rlast,
    output logic [1:0]                  err_rresp
);

    localparam logic [AXI_POINTER_BITS-1:0] SEL0 = '0;
    localparam logic [AXI_POINTER_BITS-1:0] SEL1 = AXI_POINTER_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR_A,
        S_ERR_R
    } state_t;

    state_t                      state_q, state_d;
    logic [AXI_POINTER_BITS-1:0] m_ptr_q, m_ptr_d;
    logic [AXI_POINTER_BITS-1:0] s_ptr_q, s_ptr_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [LEN_W-1:0]            beat_q, beat_d;
    logic                        last_m1_q, last_m1_d;

    logic                        grant_m1;
    logic [ADDR_W-1:0]           g_addr;
    logic [LEN_W-1:0]            g_len;
    logic                        mapped;
    logic                        unused_addr_bits;

    // M1 wins when alone, or on a tie when M0 was served last.
    assign grant_m1 = arvalid_m1 & (~arvalid_m0 | ~last_m1_q);
    assign g_addr   = grant_m1 ? araddr_m1 : araddr_m0;
    assign g_len    = grant_m1 ? arlen_m1 : arlen_m0;
    assign mapped   = (g_addr[ADDR_W-1:17] == '0);

    assign unused_addr_bits = ^g_addr[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_ptr_q   <= SEL0;
            s_ptr_q   <= SEL0;
            len_q     <= '0;
            beat_q    <= '0;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            m_ptr_q   <= m_ptr_d;
            s_ptr_q   <= s_ptr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            last_m1_q <= last_m1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_ptr_d   = m_ptr_q;
        s_ptr_d   = s_ptr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        last_m1_d = last_m1_q;
        unique case (state_q)
            S_IDLE: begin
                if (arvalid_m0 | arvalid_m1) begin
                    m_ptr_d = grant_m1 ? SEL1 : SEL0;
                    s_ptr_d = g_addr[16] ? SEL1 : SEL0;
                    len_d   = g_len;
                    beat_d  = '0;
                    state_d = mapped ? S_ADDR : S_ERR_A;
                end
            end
            S_ADDR: begin
                if (arready_s) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rvalid_s & rready_m) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (rlast_s) begin
                        state_d   = S_IDLE;
                        last_m1_d = (m_ptr_q == SEL1);
                    end
                end
            end
            S_ERR_A: begin
                state_d = S_ERR_R;
            end
            S_ERR_R: begin
                if (rready_m) begin
                    if (beat_q == len_q) begin
                        state_d   = S_IDLE;
                        last_m1_d = (m_ptr_q == SEL1);
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m_ptr       = m_ptr_q;
    assign s_ptr       = s_ptr_q;
    assign ar_en       = (state_q == S_ADDR);
    assign r_en        = (state_q == S_DATA);
    assign err_arready = (state_q == S_ERR_A);
    assign err_rvalid  = (state_q == S_ERR_R);
    assign err_rlast   = (state_q == S_ERR_R) && (beat_q == len_q);
    assign err_rresp   = err_rvalid ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_axi_read_router.sv
// Bench for axi_read_router: vector table, directed corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_axi_read_router;

    logic        clk;
    logic        rst;
    logic        arvalid_m0, arvalid_m1;
    logic [31:0] araddr_m0, araddr_m1;
    logic [3:0]  arlen_m0, arlen_m1;
    logic        arready_s, rvalid_s, rlast_s, rready_m;
    logic [0:0]  m_ptr, s_ptr;
    logic        ar_en, r_en, err_arready, err_rvalid, err_rlast;
    logic [1:0]  err_rresp;

    int total = 0;
    int bad   = 0;
    logic last_m;

    axi_read_router dut (
        .clk(clk), .rst(rst),
        .arvalid_m0(arvalid_m0), .arvalid_m1(arvalid_m1),
        .araddr_m0(araddr_m0), .araddr_m1(araddr_m1),
        .arlen_m0(arlen_m0), .arlen_m1(arlen_m1),
        .arready_s(arready_s), .rvalid_s(rvalid_s),
        .rlast_s(rlast_s), .rready_m(rready_m),
        .m_ptr(m_ptr), .s_ptr(s_ptr),
        .ar_en(ar_en), .r_en(r_en),
        .err_arready(err_arready), .err_rvalid(err_rvalid),
        .err_rlast(err_rlast), .err_rresp(err_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  req;   // {rst, arvalid_m1, arvalid_m0}
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  l0;
        logic [3:0]  l1;
        logic [3:0]  rsp;   // {arready_s, rvalid_s, rlast_s, rready_m}
        logic [6:0]  exp;   // {m, s, ar_en, r_en, err_arready, err_rvalid, err_rlast}
        logic [1:0]  rresp;
    } vec_t;

    vec_t vec [19];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic idle_in();
        rst = 1'b0;
        arvalid_m0 = 1'b0; arvalid_m1 = 1'b0;
        araddr_m0 = '0; araddr_m1 = '0;
        arlen_m0 = '0; arlen_m1 = '0;
        arready_s = 1'b0; rvalid_s = 1'b0;
        rlast_s = 1'b0; rready_m = 1'b0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_m_ptr"}, 32'(m_ptr), 0);
        chk({nm, "_s_ptr"}, 32'(s_ptr), 0);
        chk({nm, "_en"}, {30'd0, ar_en, r_en}, 0);
        chk({nm, "_err"}, {27'd0, err_arready, err_rvalid, err_rlast, err_rresp}, 0);
    endtask

    // One full transaction; rmode 1 drives rvalid=1 with rready 1,0,1,0...
    task automatic do_txn(input logic [1:0] mask, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [3:0] l0,
                          input logic [3:0] l1, input int rmode);
        logic win, err, sx, done, hs;
        logic [31:0] a;
        logic [3:0] l;
        int k, cyc, w;
        win  = (mask == 2'b10) || (mask == 2'b11 && last_m == 1'b0);
        a    = win ? a1 : a0;
        l    = win ? l1 : l0;
        err  = (a >= 32'h0002_0000);
        sx   = a[16];
        idle_in();
        arvalid_m0 = mask[0]; arvalid_m1 = mask[1];
        araddr_m0 = a0; araddr_m1 = a1;
        arlen_m0 = l0; arlen_m1 = l1;
        step();
        chk("grant_m", 32'(m_ptr), 32'(win));
        chk("grant_ar_en", 32'(ar_en), 32'(!err));
        chk("grant_err_arready", 32'(err_arready), 32'(err));
        if (!err) chk("grant_s", 32'(s_ptr), 32'(sx));
        if (win) arvalid_m1 = 1'b0; else arvalid_m0 = 1'b0;
        k = 0; cyc = 0; done = 1'b0;
        if (!err) begin
            w = (rmode == 0) ? int'($urandom_range(2, 0)) : 0;
            for (int i = 0; i < w; i++) begin
                if (win) arvalid_m1 = 1'b1; else arvalid_m0 = 1'b1;
                step();
                chk("addr_hold", {30'd0, ar_en, m_ptr}, {30'd0, 1'b1, win});
            end
            if (win) arvalid_m1 = 1'b1; else arvalid_m0 = 1'b1;
            arready_s = 1'b1;
            step();
            arready_s = 1'b0;
            if (win) arvalid_m1 = 1'b0; else arvalid_m0 = 1'b0;
            chk("data_en", {30'd0, ar_en, r_en}, 32'b01);
            while (!done && cyc < 200) begin
                rvalid_s = (rmode != 0) ? 1'b1 : 1'($urandom);
                rready_m = (rmode != 0) ? (cyc % 2 == 0) : 1'($urandom);
                rlast_s  = (k == int'(l));
                hs = rvalid_s & rready_m;
                step();
                cyc++;
                if (hs) begin
                    if (k == int'(l)) done = 1'b1;
                    k++;
                end
                chk("data_r_en", 32'(r_en), 32'(!done));
                chk("data_ptrs", {30'd0, m_ptr, s_ptr}, {30'd0, win, sx});
            end
        end else begin
            step();
            chk("err_arready_once", 32'(err_arready), 0);
            while (!done && cyc < 200) begin
                chk("err_beat", {27'd0, err_rvalid, err_rlast, err_rresp},
                    {27'd0, 1'b1, (k == int'(l)), 2'b11});
                chk("err_no_en", {30'd0, ar_en, r_en}, 0);
                chk("err_m", 32'(m_ptr), 32'(win));
                rready_m = (rmode != 0) ? (cyc % 2 == 0) : 1'($urandom);
                hs = rready_m;
                step();
                cyc++;
                if (hs) begin
                    if (k == int'(l)) done = 1'b1;
                    k++;
                end
            end
            chk("err_end", {29'd0, err_rvalid, err_rresp}, 0);
        end
        chk("beats", 32'(k), 32'(l) + 1);
        idle_in();
        last_m = win;
    endtask

    initial begin
        // reset with random inputs
        idle_in();
        rst = 1'b1;
        arvalid_m0 = 1'($urandom); arvalid_m1 = 1'($urandom);
        araddr_m0 = $urandom; araddr_m1 = $urandom;
        arready_s = 1'($urandom); rvalid_s = 1'($urandom);
        rlast_s = 1'($urandom); rready_m = 1'($urandom);
        step();
        step();
        chk_reset("reset");

        vec[0]  = '{3'b001, 32'h0001_0040, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b0110000, 2'b00};
        vec[1]  = '{3'b001, 32'h0001_0040, 32'h0, 4'd0, 4'd0, 4'b1000, 7'b0101000, 2'b00};
        vec[2]  = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0111, 7'b0100000, 2'b00};
        vec[3]  = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b0100000, 2'b00};
        vec[4]  = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b1010000, 2'b00};
        vec[5]  = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b1000, 7'b1001000, 2'b00};
        vec[6]  = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0111, 7'b1000000, 2'b00};
        vec[7]  = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b0010000, 2'b00};
        vec[8]  = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b1000, 7'b0001000, 2'b00};
        vec[9]  = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0111, 7'b0000000, 2'b00};
        vec[10] = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b1010000, 2'b00};
        vec[11] = '{3'b011, 32'h0, 32'h0, 4'd0, 4'd0, 4'b1000, 7'b1001000, 2'b00};
        vec[12] = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0110, 7'b1001000, 2'b00};
        vec[13] = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0111, 7'b1000000, 2'b00};
        vec[14] = '{3'b001, 32'h0002_0000, 32'h0, 4'd1, 4'd0, 4'b0000, 7'b0000100, 2'b00};
        vec[15] = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b0000010, 2'b11};
        vec[16] = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0000, 7'b0000010, 2'b11};
        vec[17] = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0001, 7'b0000011, 2'b11};
        vec[18] = '{3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'b0001, 7'b0000000, 2'b00};

        for (int i = 0; i < 19; i++) begin
            {rst, arvalid_m1, arvalid_m0} = vec[i].req;
            araddr_m0 = vec[i].a0; araddr_m1 = vec[i].a1;
            arlen_m0 = vec[i].l0; arlen_m1 = vec[i].l1;
            {arready_s, rvalid_s, rlast_s, rready_m} = vec[i].rsp;
            step();
            chk($sformatf("vec%0d_out", i),
                {25'd0, m_ptr, s_ptr, ar_en, r_en, err_arready, err_rvalid, err_rlast},
                {25'd0, vec[i].exp});
            chk($sformatf("vec%0d_rresp", i), 32'(err_rresp), 32'(vec[i].rresp));
        end
        last_m = 1'b0;

        // M1 len-3 burst to S0 with rready 1,0,1,0
        do_txn(2'b10, 32'h0, 32'h0000_0100, 4'd0, 4'd3, 1);

        // reset in the middle of a len-3 burst
        idle_in();
        arvalid_m1 = 1'b1; araddr_m1 = 32'h0000_0200; arlen_m1 = 4'd3;
        step();
        chk("rmid_grant", {30'd0, m_ptr, ar_en}, 32'b11);
        arready_s = 1'b1;
        step();
        arvalid_m1 = 1'b0; arready_s = 1'b0;
        rvalid_s = 1'b1; rready_m = 1'b1;
        step();
        chk("rmid_data", 32'(r_en), 1);
        rst = 1'b1;
        step();
        chk_reset("rmid_reset");
        idle_in();
        last_m = 1'b1;
        do_txn(2'b10, 32'h0, 32'h0001_0008, 4'd0, 4'd0, 0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic [1:0] mask;
            logic [31:0] ad [2];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(2, 0))
                    0: ad[j] = {16'h0000, 16'($urandom)};
                    1: ad[j] = {16'h0001, 16'($urandom)};
                    default: ad[j] = 32'h0002_0000 | $urandom;
                endcase
            end
            mask = 2'($urandom_range(3, 1));
            do_txn(mask, ad[0], ad[1], 4'($urandom), 4'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
